// File: rtl/pipelined_long_divider_if.sv
// Operand/result bundle for the pipelined long divider.
// master: issues operands and observes results (arithmetic unit front end).
// slave : the divider itself.
//   dividend_i, divisor_i : unsigned operands
//   valid_entry_i         : operands valid this cycle
//   quotient_o            : unsigned quotient
//   remainder_o           : unsigned remainder
//   divide_by_zero_o      : divisor was zero, qualified by data_valid_o
//   data_valid_o          : results valid this cycle
interface pipelined_long_divider_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  valid_entry_i;
    logic [DATA_WIDTH-1:0] quotient_o;
    logic [DATA_WIDTH-1:0] remainder_o;
    logic                  divide_by_zero_o;
    logic                  data_valid_o;

    modport master (
        output dividend_i, divisor_i, valid_entry_i,
        input  quotient_o, remainder_o, divide_by_zero_o, data_valid_o
    );

    modport slave (
        input  dividend_i, divisor_i, valid_entry_i,
        output quotient_o, remainder_o, divide_by_zero_o, data_valid_o
    );
endinterface

// File: rtl/pipelined_long_divider.sv
// Unsigned pipelined restoring long divider.
// Each of PIPELINE_DEPTH register stages resolves DATA_WIDTH/PIPELINE_DEPTH
// quotient bits MSB-first; one operation accepted per enabled cycle, latency
// PIPELINE_DEPTH enabled cycles, no backpressure.
// Ports:
//   clk_i    : rising-edge clock
//   rst_n_i  : asynchronous active-low reset, clears every stage
//   clk_en_i : global enable, low freezes all registers
//   bus      : operand/result bundle (slave side)
module pipelined_long_divider #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned PIPELINE_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clk_en_i,
    pipelined_long_divider_if.slave  bus
);
    localparam int unsigned DW             = DATA_WIDTH;
    localparam int unsigned BITS_PER_STAGE = DATA_WIDTH / PIPELINE_DEPTH;
    localparam int unsigned LAST           = PIPELINE_DEPTH - 1;

    // Reject configurations that would leave quotient bits unresolved.
    if ((PIPELINE_DEPTH == 0) || (DATA_WIDTH % PIPELINE_DEPTH != 0)) begin : g_bad_cfg
        $error("DATA_WIDTH must be a multiple of PIPELINE_DEPTH (>=1)");
    end

    // Stage registers: partial remainder (one guard bit), unconsumed dividend
    // bits, divisor, quotient so far, divide-by-zero flag, valid bit.
    logic [DW:0]   rem_q [PIPELINE_DEPTH];
    logic [DW-1:0] dvd_q [PIPELINE_DEPTH];
    logic [DW-1:0] dvs_q [PIPELINE_DEPTH];
    logic [DW-1:0] quo_q [PIPELINE_DEPTH];
    logic          dbz_q [PIPELINE_DEPTH];
    logic          vld_q [PIPELINE_DEPTH];

    // Stage inputs and next-state values.
    logic [DW:0]   rem_s [PIPELINE_DEPTH];
    logic [DW-1:0] dvd_s [PIPELINE_DEPTH];
    logic [DW-1:0] dvs_s [PIPELINE_DEPTH];
    logic [DW-1:0] quo_s [PIPELINE_DEPTH];
    logic          dbz_s [PIPELINE_DEPTH];
    logic          vld_s [PIPELINE_DEPTH];

    logic [DW:0]   rem_d [PIPELINE_DEPTH];
    logic [DW-1:0] dvd_d [PIPELINE_DEPTH];
    logic [DW-1:0] dvs_d [PIPELINE_DEPTH];
    logic [DW-1:0] quo_d [PIPELINE_DEPTH];
    logic          dbz_d [PIPELINE_DEPTH];
    logic          vld_d [PIPELINE_DEPTH];

    // Restoring division iterations for every stage.
    always_comb begin
        logic [DW:0]   rem;
        logic [DW-1:0] dvd;
        logic [DW-1:0] quo;

        rem   = '0;
        dvd   = '0;
        quo   = '0;
        rem_s = '{default: '0};
        dvd_s = '{default: '0};
        dvs_s = '{default: '0};
        quo_s = '{default: '0};
        dbz_s = '{default: 1'b0};
        vld_s = '{default: 1'b0};
        rem_d = '{default: '0};
        dvd_d = '{default: '0};
        dvs_d = '{default: '0};
        quo_d = '{default: '0};
        dbz_d = '{default: 1'b0};
        vld_d = '{default: 1'b0};

        // Stage 0 consumes the operands directly with an empty partial remainder.
        rem_s[0] = '0;
        dvd_s[0] = bus.dividend_i;
        dvs_s[0] = bus.divisor_i;
        quo_s[0] = '0;
        dbz_s[0] = bus.valid_entry_i && (bus.divisor_i == '0);
        vld_s[0] = bus.valid_entry_i;

        for (int unsigned k = 1; k < PIPELINE_DEPTH; k++) begin
            rem_s[k] = rem_q[k-1];
            dvd_s[k] = dvd_q[k-1];
            dvs_s[k] = dvs_q[k-1];
            quo_s[k] = quo_q[k-1];
            dbz_s[k] = dbz_q[k-1];
            vld_s[k] = vld_q[k-1];
        end

        for (int unsigned k = 0; k < PIPELINE_DEPTH; k++) begin
            rem = rem_s[k];
            dvd = dvd_s[k];
            quo = quo_s[k];
            for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
                rem = {rem[DW-1:0], dvd[DW-1]};
                dvd = {dvd[DW-2:0], 1'b0};
                if (rem >= {1'b0, dvs_s[k]}) begin
                    rem = rem - {1'b0, dvs_s[k]};
                    quo = {quo[DW-2:0], 1'b1};
                end else begin
                    quo = {quo[DW-2:0], 1'b0};
                end
            end
            rem_d[k] = rem;
            dvd_d[k] = dvd;
            dvs_d[k] = dvs_s[k];
            quo_d[k] = quo;
            dbz_d[k] = dbz_s[k];
            vld_d[k] = vld_s[k];
        end

        // A zero divisor already yields all-ones and R == dividend, since every
        // dividend bit is shifted into R; the quotient is pinned regardless.
        if (dbz_d[LAST]) begin
            quo_d[LAST] = '1;
        end
        // Bubbles leave zeroed results so outputs only show real data.
        if (!vld_d[LAST]) begin
            quo_d[LAST] = '0;
            rem_d[LAST] = '0;
        end
    end

    // Stage registers; clk_en_i low freezes the whole pipe, valid bits included.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q <= '{default: '0};
            dvd_q <= '{default: '0};
            dvs_q <= '{default: '0};
            quo_q <= '{default: '0};
            dbz_q <= '{default: 1'b0};
            vld_q <= '{default: 1'b0};
        end else if (clk_en_i) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            dbz_q <= dbz_d;
            vld_q <= vld_d;
        end
    end

    assign bus.quotient_o       = quo_q[LAST];
    assign bus.remainder_o      = rem_q[LAST][DW-1:0];
    assign bus.divide_by_zero_o = dbz_q[LAST];
    assign bus.data_valid_o     = vld_q[LAST];
endmodule

// File: tb/tb_pipelined_long_divider.sv
// Self-checking bench for pipelined_long_divider. Five instances with
// PIPELINE_DEPTH 1, 2, 4, 8, 16 share one operand stream; a history of
// operands sampled on enabled edges predicts each instance's outputs with
// plain / and % arithmetic.
module tb_pipelined_long_divider;
    localparam int unsigned DW   = 16;
    localparam int unsigned NDUT = 5;
    localparam int          REF  = 2;   // depth-4 instance

    typedef struct {
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic clk_en_i;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          valid_entry;

    logic [NDUT-1:0][DW-1:0] q_o;
    logic [NDUT-1:0][DW-1:0] r_o;
    logic [NDUT-1:0]         dbz_o;
    logic [NDUT-1:0]         dv_o;

    op_t hist[$];
    int  reset_cnt;
    int  total;
    int  bad;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipelined_long_divider_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.dividend_i    = dividend;
        assign bus.divisor_i     = divisor;
        assign bus.valid_entry_i = valid_entry;
        assign q_o[g]   = bus.quotient_o;
        assign r_o[g]   = bus.remainder_o;
        assign dbz_o[g] = bus.divide_by_zero_o;
        assign dv_o[g]  = bus.data_valid_o;

        pipelined_long_divider #(
            .DATA_WIDTH    (DW),
            .PIPELINE_DEPTH(1 << g)
        ) u_dut (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .clk_en_i(clk_en_i),
            .bus     (bus)
        );
    end

    task automatic cmp(input string name, input int g, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s depth=%0d got=%0h want=%0h t=%0t", name, 1 << g, got, exp, $time);
        end
    endtask

    // Model: output after the latest enabled edge E comes from the operand
    // sampled on edge E-depth+1; anything sampled before a reset is discarded.
    task automatic check_all();
        for (int g = 0; g < NDUT; g++) begin
            int            idx;
            op_t           op;
            logic          ev;
            logic          ed;
            logic [DW-1:0] eq;
            logic [DW-1:0] er;
            ev = 1'b0; ed = 1'b0; eq = '0; er = '0;
            if (rst_n_i) begin
                idx = hist.size() - (1 << g);
                if (idx >= reset_cnt) begin
                    op = hist[idx];
                    ev = op.v;
                    if (op.b == '0) begin
                        eq = '1; er = op.a; ed = 1'b1;
                    end else begin
                        eq = op.a / op.b; er = op.a % op.b;
                    end
                end
            end
            cmp("valid", g, DW'(dv_o[g]), DW'(ev));
            if (ev || !rst_n_i) begin
                cmp("quotient", g, q_o[g], eq);
                cmp("remainder", g, r_o[g], er);
                cmp("dbz", g, DW'(dbz_o[g]), DW'(ed));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_n_i && clk_en_i) hist.push_back('{v: valid_entry, a: dividend, b: divisor});
        @(negedge clk_i);
        check_all();
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic v);
        dividend    = a;
        divisor     = b;
        valid_entry = v;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue('0, '0, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; reset_cnt = 0;
        rst_n_i = 1'b0; clk_en_i = 1'b1;
        dividend = '0; divisor = '0; valid_entry = 1'b0;

        // reset state
        @(negedge clk_i);
        check_all();
        tick(); tick();
        cmp("rst_valid", REF, DW'(dv_o[REF]), 16'd0);
        cmp("rst_quot", REF, q_o[REF], 16'd0);
        rst_n_i   = 1'b1;
        reset_cnt = hist.size();

        // 1000 / 7, single operation
        issue(16'd1000, 16'd7, 1'b1);
        cmp("d1_1000_7_q", 0, q_o[0], 16'd142);
        cmp("d1_1000_7_r", 0, r_o[0], 16'd6);
        idle(2);
        cmp("d4_early_valid", REF, DW'(dv_o[REF]), 16'd0);
        idle(1);
        cmp("d4_1000_7_valid", REF, DW'(dv_o[REF]), 16'd1);
        cmp("d4_1000_7_q", REF, q_o[REF], 16'd142);
        cmp("d4_1000_7_r", REF, r_o[REF], 16'd6);
        cmp("d4_1000_7_dbz", REF, DW'(dbz_o[REF]), 16'd0);
        idle(1);
        cmp("d4_1000_7_pulse", REF, DW'(dv_o[REF]), 16'd0);

        // boundaries, divide by zero and its follower
        issue(16'hFFFF, 16'd1, 1'b1);
        cmp("ffff_1_q", 0, q_o[0], 16'hFFFF);
        cmp("ffff_1_r", 0, r_o[0], 16'd0);
        issue(16'd3, 16'd10, 1'b1);
        cmp("3_10_q", 0, q_o[0], 16'd0);
        cmp("3_10_r", 0, r_o[0], 16'd3);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        cmp("ffff_ffff_q", 0, q_o[0], 16'd1);
        cmp("ffff_ffff_r", 0, r_o[0], 16'd0);
        issue(16'd0, 16'd5, 1'b1);
        cmp("0_5_q", 0, q_o[0], 16'd0);
        cmp("0_5_r", 0, r_o[0], 16'd0);
        issue(16'd5, 16'd0, 1'b1);
        cmp("5_0_q", 0, q_o[0], 16'hFFFF);
        cmp("5_0_r", 0, r_o[0], 16'd5);
        cmp("5_0_dbz", 0, DW'(dbz_o[0]), 16'd1);
        issue(16'd6, 16'd3, 1'b1);
        cmp("6_3_q", 0, q_o[0], 16'd2);
        cmp("6_3_dbz", 0, DW'(dbz_o[0]), 16'd0);
        idle(2);
        cmp("d4_5_0_q", REF, q_o[REF], 16'hFFFF);
        cmp("d4_5_0_r", REF, r_o[REF], 16'd5);
        cmp("d4_5_0_dbz", REF, DW'(dbz_o[REF]), 16'd1);
        idle(1);
        cmp("d4_6_3_q", REF, q_o[REF], 16'd2);
        cmp("d4_6_3_dbz", REF, DW'(dbz_o[REF]), 16'd0);
        idle(16);

        // back-to-back stream with one bubble
        issue(16'd12345, 16'd67, 1'b1);
        issue(16'd40000, 16'd3, 1'b1);
        issue(16'd7, 16'd7, 1'b1);
        issue(16'd0, 16'd0, 1'b0);
        issue(16'd65535, 16'd256, 1'b1);
        issue(16'd1, 16'd65535, 1'b1);
        issue(16'd999, 16'd10, 1'b1);
        issue(16'd32768, 16'd2, 1'b1);
        cmp("stream_valid", REF, DW'(dv_o[REF]), 16'd1);
        cmp("stream_q", REF, q_o[REF], 16'd255);
        cmp("stream_r", REF, r_o[REF], 16'd255);
        idle(18);

        // stall mid-flight
        issue(16'd100, 16'd9, 1'b1);
        cmp("d1_100_9_q", 0, q_o[0], 16'd11);
        idle(1);
        clk_en_i = 1'b0;
        idle(3);
        cmp("stall_d4_not_yet", REF, DW'(dv_o[REF]), 16'd0);
        clk_en_i = 1'b1;
        idle(2);
        cmp("stall_d4_valid", REF, DW'(dv_o[REF]), 16'd1);
        cmp("stall_d4_q", REF, q_o[REF], 16'd11);
        cmp("stall_d4_r", REF, r_o[REF], 16'd1);
        clk_en_i = 1'b0;
        idle(2);
        cmp("stall_hold_valid", REF, DW'(dv_o[REF]), 16'd1);
        cmp("stall_hold_q", REF, q_o[REF], 16'd11);
        clk_en_i = 1'b1;
        idle(18);

        // asynchronous reset with operations in flight
        issue(16'd200, 16'd3, 1'b1);
        issue(16'd300, 16'd7, 1'b1);
        issue(16'd400, 16'd9, 1'b1);
        #2;
        rst_n_i   = 1'b0;
        reset_cnt = hist.size();
        #1;
        check_all();
        cmp("async_rst_d1_valid", 0, DW'(dv_o[0]), 16'd0);
        cmp("async_rst_d1_q", 0, q_o[0], 16'd0);
        tick(); tick();
        rst_n_i = 1'b1;
        idle(6);
        cmp("post_rst_no_valid", REF, DW'(dv_o[REF]), 16'd0);
        issue(16'd50, 16'd8, 1'b1);
        cmp("d1_50_8_q", 0, q_o[0], 16'd6);
        idle(3);
        cmp("d4_50_8_valid", REF, DW'(dv_o[REF]), 16'd1);
        cmp("d4_50_8_q", REF, q_o[REF], 16'd6);
        cmp("d4_50_8_r", REF, r_o[REF], 16'd2);
        idle(16);

        // random operands with zero divisors, bubbles and stalls
        for (int n = 0; n < 10000; n++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            int unsigned   sel;
            sel = $urandom_range(99);
            a   = DW'($urandom);
            if (sel < 10)      b = '0;
            else if (sel < 40) b = DW'($urandom_range(255, 1));
            else               b = DW'($urandom);
            clk_en_i = ($urandom_range(19) != 0);
            issue(a, b, $urandom_range(9) != 0);
        end
        clk_en_i = 1'b1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_long_divider.md
Name: pipelined_long_divider

Overview:
Unsigned pipelined restoring long divider, the inverse companion of the team's pipelined long multiplier. It computes quotient and remainder of a DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor. The work is split across PIPELINE_DEPTH registered stages, each resolving DATA_WIDTH/PIPELINE_DEPTH quotient bits MSB-first. It accepts one operation per enabled cycle and sits in the integer arithmetic unit beside the multiplier.

Parameters:
DATA_WIDTH, 16, operand/quotient/remainder width; must be divisible by PIPELINE_DEPTH.
PIPELINE_DEPTH, 4, number of register stages (>=1); equals latency in enabled cycles.

Ports:
clk_i  input  1  clock, rising-edge.
rst_n_i  input  1  reset, asynchronous, active-low.
clk_en_i  input  1  global enable; low freezes every register.
dividend_i  input  DATA_WIDTH  unsigned dividend.
divisor_i  input  DATA_WIDTH  unsigned divisor.
valid_entry_i  input  1  operands valid this cycle.
quotient_o  output  DATA_WIDTH  unsigned quotient.
remainder_o  output  DATA_WIDTH  unsigned remainder.
divide_by_zero_o  output  1  divisor was zero.
data_valid_o  output  1  outputs valid this cycle.

Behaviour:
- Reset: clocking and reset are on clk_i and rst_n_i (asynchronous, active-low). Reset clears all stage registers. quotient_o, remainder_o, divide_by_zero_o and data_valid_o read 0 while rst_n_i is low and until new results emerge.
- Local parameter BITS_PER_STAGE = DATA_WIDTH/PIPELINE_DEPTH.
- Per-stage state carried in registers:
  - partial remainder (DATA_WIDTH+1 bits, guards the subtract carry);
  - remaining dividend bits, shifted left;
  - divisor;
  - quotient bits accumulated so far;
  - divide-by-zero flag;
  - valid bit.
- Stage k runs BITS_PER_STAGE combinational iterations. Each iteration:
  - R = {R, next dividend MSB};
  - if R >= divisor: R -= divisor and the quotient bit is 1;
  - otherwise the quotient bit is 0.
  - Quotient bits are shifted in LSB-side.
- Stage 0 takes dividend_i, divisor_i and valid_entry_i directly with R = 0. Its results are registered at the end of the cycle.
- Output comes from the final stage's register; there is no combinational path from inputs to outputs.
- Latency: an operation sampled with valid_entry_i=1 on enabled edge N appears with data_valid_o=1 after enabled edge N+PIPELINE_DEPTH-1, i.e. visible for the cycle following that edge.
- Throughput is one operation per enabled cycle. There is no backpressure and no busy signal.
- clk_en_i=0: all registers hold, including the valid bits. Outputs stay stable, and a held data_valid_o=1 stays asserted. Stalled cycles do not count toward latency.
- Bubbles: valid_entry_i=0 propagates a 0 valid bit. Datapath registers still load (don't-care contents), and the bench checks data only when data_valid_o=1.
- Divide by zero (divisor_i == 0): the stage 0 flag is set and carried through. Final outputs are quotient_o = all ones, remainder_o = dividend, divide_by_zero_o = 1. The restoring algorithm yields exactly this naturally, and the output logic also forces it explicitly.
- divide_by_zero_o is 0 for nonzero divisors and is qualified by data_valid_o.
- Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for divisor != 0.
- Reset mid-operation: all in-flight operations are discarded and no data_valid_o pulse is produced for them after reset release.
- Assertion (simulation only): DATA_WIDTH % PIPELINE_DEPTH == 0.

Test Plan:
- DATA_WIDTH=16, PIPELINE_DEPTH=4, clk_en_i=1. Input 1000/7 -> after 4 cycles: quotient 142, remainder 6, dbz 0, data_valid_o for exactly one cycle.
- Boundaries:
  - 0xFFFF/1 -> q 0xFFFF, r 0;
  - 3/10 -> q 0, r 3;
  - 0xFFFF/0xFFFF -> q 1, r 0;
  - 0/5 -> q 0, r 0.
- 5/0 -> q 0xFFFF, r 5, divide_by_zero_o=1. An immediately following 6/3 -> q 2, r 0, dbz 0.
- Back-to-back stream of 8 operations (including a one-cycle bubble) -> results in order, one per cycle, bubble reproduced in data_valid_o, 4-cycle latency each.
- Stall: issue 100/9, drop clk_en_i for 3 cycles mid-flight -> no output change during stall; q 11, r 1 appears 4 enabled edges after issue; data_valid_o holds while stalled.
- Reset: assert rst_n_i low asynchronously with 3 operations in flight -> outputs 0 immediately; after release, no spurious data_valid_o; a new 50/8 -> q 6, r 2.
- Random: 10k random operand pairs (10% zero divisors) checked against a reference model, with PIPELINE_DEPTH in {1, 2, 4, 8, 16}.
